// File: rtl/uart_cmd_resp.sv
// Command/response engine behind a UART byte link: pairs received bytes into
// 16-bit commands and pushes single-byte responses out through the transmitter.
//
// state    | meaning
// IDLE     | waiting for the high command byte
// WAIT_LOW | high byte held, waiting (with timeout) for the low byte
// HOLD     | command presented on cmd/cmd_rdy, receiver back-pressured
// TX_IDLE  | no response in flight
// TX_START | one-cycle trmt pulse to the transmitter
// TX_WAIT  | waiting for the transmitter to report done
module uart_cmd_resp #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_busy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, HOLD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;

    rx_state_t     rx_state;
    tx_state_t     tx_state;
    logic [CW-1:0] tmo_cnt;
    logic          guard;
    logic          low_seen;
    logic [1:0]    wait_cnt;

    // guard masks the cycle after a capture, while rx_rdy is still the old byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= IDLE;
            tmo_cnt    <= '0;
            guard      <= 1'b0;
            clr_rx_rdy <= 1'b0;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
        end else begin
            clr_rx_rdy <= 1'b0;
            guard      <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (rx_rdy && !guard) begin
                        cmd[15:8]  <= rx_data;
                        clr_rx_rdy <= 1'b1;
                        guard      <= 1'b1;
                        tmo_cnt    <= '0;
                        rx_state   <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (rx_rdy && !guard) begin
                        cmd[7:0]   <= rx_data;
                        clr_rx_rdy <= 1'b1;
                        guard      <= 1'b1;
                        cmd_rdy    <= 1'b1;
                        rx_state   <= HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rx_state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy  <= 1'b0;
                        rx_state <= IDLE;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // a done level left high from the previous byte is ignored until the
    // transmitter has shown low, or enough cycles have passed for it to have started
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            resp_busy <= 1'b0;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            low_seen  <= 1'b0;
            wait_cnt  <= 2'd0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data   <= resp;
                        resp_busy <= 1'b1;
                        trmt      <= 1'b1;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    trmt     <= 1'b0;
                    low_seen <= 1'b0;
                    wait_cnt <= 2'd0;
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done && (low_seen || wait_cnt == 2'd2)) begin
                        resp_busy <= 1'b0;
                        tx_state  <= TX_IDLE;
                    end else begin
                        if (!tx_done) low_seen <= 1'b1;
                        if (wait_cnt != 2'd2) wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Directed bench for uart_cmd_resp: command assembly, timeout, back-pressure,
// response handshake and mid-operation reset, with hand-computed expectations.
module tb_uart_cmd_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        resp_busy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int clr_cnt = 0;
    int trmt_cnt = 0;

    uart_cmd_resp #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp), .resp_busy(resp_busy),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_rx_rdy) clr_cnt++;
        if (trmt) trmt_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // receiver model: rx_rdy held until the clr pulse is seen, dropped after it
    task automatic wait_clr(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) seen = 1'b1;
        end
        check({tag, " clr"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        rx_data = b;
        rx_rdy  = 1'b1;
        wait_clr(tag);
    endtask

    task automatic ack_cmd(input string tag);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check({tag, " cmd_rdy cleared"}, 32'(cmd_rdy), 32'd0);
    endtask

    initial begin
        int c0;
        int t0;
        bit any_rdy;

        // reset state
        tick(); tick();
        check("rst clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
        check("rst cmd",        32'(cmd),        32'h0000);
        check("rst cmd_rdy",    32'(cmd_rdy),    32'd0);
        check("rst resp_busy",  32'(resp_busy),  32'd0);
        check("rst trmt",       32'(trmt),       32'd0);
        check("rst tx_data",    32'(tx_data),    32'h00);
        rst = 1'b0;
        tick();

        // 1: basic command A53C
        c0 = clr_cnt;
        send_byte(8'hA5, "t1 hi");
        check("t1 no cmd_rdy after hi", 32'(cmd_rdy), 32'd0);
        send_byte(8'h3C, "t1 lo");
        check("t1 cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("t1 cmd", 32'(cmd), 32'hA53C);
        repeat (3) tick();
        check("t1 cmd_rdy held", 32'(cmd_rdy), 32'd1);
        check("t1 cmd held", 32'(cmd), 32'hA53C);
        check("t1 clr pulses", 32'(clr_cnt - c0), 32'd2);
        ack_cmd("t1");

        // 2: timeout discards the lone high byte
        send_byte(8'h12, "t2 hi");
        any_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_rdy) any_rdy = 1'b1;
        end
        check("t2 no cmd after timeout", 32'(any_rdy), 32'd0);
        send_byte(8'h34, "t2 hi2");
        send_byte(8'h56, "t2 lo2");
        check("t2 cmd", 32'(cmd), 32'h3456);
        check("t2 cmd_rdy", 32'(cmd_rdy), 32'd1);
        ack_cmd("t2");

        // 2b: low byte on the timeout cycle itself wins
        send_byte(8'h21, "t2b hi");
        repeat (14) @(posedge clk);
        #1;
        send_byte(8'h43, "t2b lo");
        check("t2b cmd_rdy at timeout edge", 32'(cmd_rdy), 32'd1);
        check("t2b cmd", 32'(cmd), 32'h2143);
        ack_cmd("t2b");

        // 2c: one cycle later the byte becomes a new high byte
        send_byte(8'h65, "t2c hi");
        repeat (15) @(posedge clk);
        #1;
        send_byte(8'h87, "t2c late");
        check("t2c no cmd_rdy", 32'(cmd_rdy), 32'd0);
        send_byte(8'h09, "t2c lo");
        check("t2c cmd", 32'(cmd), 32'h8709);
        ack_cmd("t2c");

        // 3: back-pressure while cmd_rdy
        send_byte(8'hBE, "t3 hi");
        send_byte(8'hEF, "t3 lo");
        check("t3 cmd", 32'(cmd), 32'hBEEF);
        c0 = clr_cnt;
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        repeat (4) tick();
        check("t3 no clr in HOLD", 32'(clr_cnt - c0), 32'd0);
        check("t3 cmd frozen", 32'(cmd), 32'hBEEF);
        ack_cmd("t3");
        check("t3 no clr on ack cycle", 32'(clr_cnt - c0), 32'd0);
        wait_clr("t3 pending");
        send_byte(8'h01, "t3 lo2");
        check("t3 cmd after", 32'(cmd), 32'h7701);
        ack_cmd("t3b");

        // 4: slow receiver clear -> single capture
        c0 = clr_cnt;
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        tick(); tick();
        rx_rdy = 1'b0;
        repeat (3) tick();
        check("t4 one clr", 32'(clr_cnt - c0), 32'd1);
        check("t4 not HOLD", 32'(cmd_rdy), 32'd0);
        send_byte(8'h42, "t4 lo");
        check("t4 cmd", 32'(cmd), 32'h9942);
        ack_cmd("t4");

        // 5: response handshake
        t0 = trmt_cnt;
        resp = 8'hC3;
        send_resp = 1'b1;
        tick();
        resp = 8'h00;
        check("t5 trmt", 32'(trmt), 32'd1);
        check("t5 tx_data", 32'(tx_data), 32'hC3);
        check("t5 busy", 32'(resp_busy), 32'd1);
        tx_done = 1'b0;
        tick();
        send_resp = 1'b0;
        check("t5 trmt one cycle", 32'(trmt), 32'd0);
        check("t5 busy while shifting", 32'(resp_busy), 32'd1);
        check("t5 tx_data held", 32'(tx_data), 32'hC3);
        tick();
        tx_done = 1'b1;
        check("t5 busy before done", 32'(resp_busy), 32'd1);
        tick();
        check("t5 busy falls", 32'(resp_busy), 32'd0);
        check("t5 tx_data kept", 32'(tx_data), 32'hC3);
        check("t5 ignored send", 32'(trmt_cnt - t0), 32'd1);
        resp = 8'h5A;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        check("t5 back-to-back trmt", 32'(trmt), 32'd1);
        check("t5 back-to-back data", 32'(tx_data), 32'h5A);
        tick();
        check("t5 stale done masked", 32'(resp_busy), 32'd1);
        for (int i = 0; i < 8 && resp_busy; i++) tick();
        check("t5 stale busy falls", 32'(resp_busy), 32'd0);
        check("t5 trmt count", 32'(trmt_cnt - t0), 32'd2);

        // 6: reset mid-operation
        send_byte(8'h55, "t6 hi");
        tx_done = 1'b0;
        resp = 8'h11;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("t6 cmd",       32'(cmd),       32'h0000);
        check("t6 cmd_rdy",   32'(cmd_rdy),   32'd0);
        check("t6 clr",       32'(clr_rx_rdy), 32'd0);
        check("t6 busy",      32'(resp_busy), 32'd0);
        check("t6 trmt",      32'(trmt),      32'd0);
        check("t6 tx_data",   32'(tx_data),   32'h00);
        rst = 1'b0;
        tx_done = 1'b1;
        tick();
        send_byte(8'h01, "t6 hi2");
        send_byte(8'h02, "t6 lo2");
        check("t6 cmd after", 32'(cmd), 32'h0102);
        check("t6 cmd_rdy after", 32'(cmd_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
